id_hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage core. It sits beside the ID stage and takes decode register reads, the ID/EX load/destination fields, EX branch resolution and the data-memory busy flag. From these it drives the PC and pipeline-register enables and the flush (bubble) controls. It also sequences post-reset pipeline fill, enforces a data-memory wait timeout and keeps saturating stall and flush counters.

---
 rtl/id_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// Hazard/sequencing controller beside ID: load-use stalls, branch flushes,
// post-reset bubble fill, data-memory freeze with timeout, perf counters.
module id_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_idValid,
    input  logic [4:0]       i_idRs1,
    input  logic [4:0]       i_idRs2,
    input  logic             i_exMemRead,
    input  logic [4:0]       i_exRd,
    input  logic             i_brTaken,
    input  logic             i_memBusy,
    output logic             o_pcEn,
    output logic             o_ifidEn,
    output logic             o_ifidFlush,
    output logic             o_idexFlush,
    output logic             o_pipeEn,
    output logic [1:0]       o_state,
    output logic             o_memErr,
    output logic [CNT_W-1:0] o_stallCnt,
    output logic [CNT_W-1:0] o_flushCnt
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     init_cnt;
    logic [WW-1:0]     wait_cnt;
    logic              lu;
    logic              stall_evt;
    logic              flush_evt;
    logic              active;

    assign lu = i_exMemRead & i_idValid & (i_exRd != 5'd0) &
                ((i_idRs1 == i_exRd) | (i_idRs2 == i_exRd));

    assign active  = (state == S_RUN) | (state == S_WAIT);
    assign o_state = state;

    always_comb begin
        state_nxt   = state;
        o_pcEn      = 1'b0;
        o_ifidEn    = 1'b1;
        o_ifidFlush = 1'b1;
        o_idexFlush = 1'b1;
        o_pipeEn    = 1'b1;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        case (state)
            S_RUN, S_WAIT: begin
                // Freeze outranks a taken branch; EX re-presents it later.
                if (i_memBusy) begin
                    o_ifidEn    = 1'b0;
                    o_ifidFlush = 1'b0;
                    o_idexFlush = 1'b0;
                    o_pipeEn    = 1'b0;
                    stall_evt   = 1'b1;
                    state_nxt   = S_WAIT;
                end else begin
                    state_nxt = S_RUN;
                    if (i_brTaken) begin
                        o_pcEn    = 1'b1;
                        flush_evt = 1'b1;
                    end else if (lu) begin
                        o_ifidEn    = 1'b0;
                        o_ifidFlush = 1'b0;
                        stall_evt   = 1'b1;
                    end else begin
                        o_pcEn      = 1'b1;
                        o_ifidFlush = 1'b0;
                        o_idexFlush = 1'b0;
                    end
                end
            end
            S_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT && init_cnt != INIT_LAST) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Wait counter parks at its last value; the error flag is sticky anyway.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt <= '0;
            o_memErr <= 1'b0;
        end else if (active && i_memBusy) begin
            if (wait_cnt == WAIT_LAST) begin
                o_memErr <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stallCnt <= '0;
            o_flushCnt <= '0;
        end else begin
            if (stall_evt && o_stallCnt != '1) begin
                o_stallCnt <= o_stallCnt + 1'b1;
            end
            if (flush_evt && o_flushCnt != '1) begin
                o_flushCnt <= o_flushCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed + randomized bench for id_hazard_ctrl with a rule-level model.
module tb_id_hazard_ctrl;

    localparam int CNT_W       = 2;
    localparam int INIT_CYCLES = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             br_taken;
    logic             mem_busy;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pipe_en;
    logic [1:0]       state;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0=fill, 1=run, 2=waiting on memory
    int m_phase;
    int m_fill;
    int m_busy_run;
    int m_stall;
    int m_flush;
    bit m_err;

    id_hazard_ctrl #(
        .CNT_W(CNT_W),
        .INIT_CYCLES(INIT_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_idValid(id_valid),
        .i_idRs1(rs1),
        .i_idRs2(rs2),
        .i_exMemRead(ex_mem_read),
        .i_exRd(ex_rd),
        .i_brTaken(br_taken),
        .i_memBusy(mem_busy),
        .o_pcEn(pc_en),
        .o_ifidEn(ifid_en),
        .o_ifidFlush(ifid_flush),
        .o_idexFlush(idex_flush),
        .o_pipeEn(pipe_en),
        .o_state(state),
        .o_memErr(mem_err),
        .o_stallCnt(stall_cnt),
        .o_flushCnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit load_use();
        return ex_mem_read && id_valid && ex_rd != 0 &&
               (rs1 == ex_rd || rs2 == ex_rd);
    endfunction

    task automatic model_reset();
        m_phase    = 0;
        m_fill     = 0;
        m_busy_run = 0;
        m_stall    = 0;
        m_flush    = 0;
        m_err      = 0;
    endtask

    // Expected control word {pc, ifid_en, ifid_flush, idex_flush, pipe}
    function automatic logic [4:0] exp_ctrl();
        if (m_phase == 0) return 5'b01111;
        if (mem_busy)     return 5'b00000;
        if (br_taken)     return 5'b11111;
        if (load_use())   return 5'b00011;
        return 5'b11001;
    endfunction

    task automatic check_now();
        logic [4:0] e;
        e = exp_ctrl();
        chk("ctrl", {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en}, e);
        chk("state", state, m_phase);
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic model_step();
        if (m_phase == 0) begin
            m_fill++;
            if (m_fill == INIT_CYCLES) m_phase = 1;
        end else if (mem_busy) begin
            m_stall    = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            m_busy_run = m_busy_run + 1;
            if (m_busy_run >= MEM_TIMEOUT) m_err = 1;
            m_phase = 2;
        end else begin
            m_busy_run = 0;
            if (br_taken)
                m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            else if (load_use())
                m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            m_phase = 1;
        end
    endtask

    // Inputs are changed at posedge+1; check on negedge, advance model on posedge.
    task automatic cycle();
        @(negedge clk);
        check_now();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        id_valid    = 1'b0;
        rs1         = 5'd0;
        rs2         = 5'd0;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        br_taken    = 1'b0;
        mem_busy    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (INIT_CYCLES) cycle();
    endtask

    task automatic set_lu(input logic [4:0] rd);
        id_valid    = 1'b1;
        ex_mem_read = 1'b1;
        ex_rd       = rd;
        rs1         = 5'd7;
        rs2         = 5'd5;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        // Reset fill
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_flush", {ifid_flush, idex_flush}, 2'b11);
        chk("rst_state", state, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("fill1_pc_en", pc_en, 1'b0);
        cycle();
        chk("fill2_flush", {ifid_flush, idex_flush}, 2'b11);
        cycle();
        chk("run_state", state, 2'b01);
        chk("run_pc_en", pc_en, 1'b1);

        // Load-use then bubble (exRd=0)
        set_lu(5'd5);
        #1;
        chk("lu_ctrl", {pc_en, ifid_en, idex_flush}, 3'b001);
        cycle();
        ex_rd = 5'd0;
        #1;
        chk("lu_rd0_nostall", {pc_en, ifid_en, idex_flush}, 3'b110);
        cycle();
        chk("lu_stall_cnt", stall_cnt, 2'd1);

        // Branch over load-use
        set_lu(5'd5);
        br_taken = 1'b1;
        #1;
        chk("br_lu_ctrl", {pc_en, ifid_flush, idex_flush}, 3'b111);
        cycle();
        idle_inputs();
        cycle();
        chk("br_flush_cnt", flush_cnt, 2'd1);
        chk("br_stall_cnt", stall_cnt, 2'd1);

        // Memory wait with pending branch
        do_reset();
        mem_busy = 1'b1;
        br_taken = 1'b1;
        #1;
        chk("wait_freeze", {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush},
            5'b00000);
        repeat (3) cycle();
        chk("wait_state", state, 2'b10);
        mem_busy = 1'b0;
        #1;
        chk("wait_release_flush", {pc_en, ifid_flush, idex_flush}, 3'b111);
        cycle();
        chk("wait_stall_cnt", stall_cnt, 2'd3);
        chk("wait3_no_err", mem_err, 1'b0);

        // Timeout
        br_taken = 1'b0;
        mem_busy = 1'b1;
        repeat (3) cycle();
        chk("to3_no_err", mem_err, 1'b0);
        cycle();
        chk("to4_err", mem_err, 1'b1);
        mem_busy = 1'b0;
        repeat (2) cycle();
        chk("to_sticky", mem_err, 1'b1);
        do_reset();
        chk("to_cleared", mem_err, 1'b0);

        // Saturation: five bubbles
        for (int i = 0; i < 5; i++) begin
            set_lu(5'd5);
            cycle();
            idle_inputs();
            cycle();
        end
        chk("sat_stall_cnt", stall_cnt, 2'd3);

        // Randomized run against the model
        begin
            int burst;
            burst = 0;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 59) == 0) begin
                    rst_n = 1'b0;
                    model_reset();
                end else begin
                    rst_n = 1'b1;
                end
                id_valid    = 1'($urandom_range(0, 3) != 0);
                rs1         = 5'($urandom_range(0, 3));
                rs2         = 5'($urandom_range(0, 3));
                ex_mem_read = 1'($urandom_range(0, 1));
                ex_rd       = 5'($urandom_range(0, 3));
                br_taken    = 1'($urandom_range(0, 4) == 0);
                if (burst == 0 && $urandom_range(0, 15) == 0)
                    burst = $urandom_range(1, 6);
                if (burst > 0) begin
                    mem_busy = 1'b1;
                    burst--;
                end else begin
                    mem_busy = 1'($urandom_range(0, 5) == 0);
                end
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
